// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both cache request/response ports, the shared
// main-memory port and the status flags of the two-port memory arbiter.
// The arbiter connects through the slave modport; the caches and memory
// model (or a testbench standing in for them) use the master modport.
interface mem_arbiter_if #(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128
);

   // Instruction cache port (port 0)
   logic                   c0_req_valid;
   logic                   c0_req_ready;
   logic [ADDR_BITS-1:0]   c0_req_addr;
   logic                   c0_req_rw;
   logic                   c0_req_data_valid;
   logic                   c0_req_data_ready;
   logic [DATA_BITS-1:0]   c0_req_data_bits;
   logic [DATA_BITS/8-1:0] c0_req_data_mask;
   logic                   c0_resp_valid;
   logic [DATA_BITS-1:0]   c0_resp_data;

   // Data cache port (port 1)
   logic                   c1_req_valid;
   logic                   c1_req_ready;
   logic [ADDR_BITS-1:0]   c1_req_addr;
   logic                   c1_req_rw;
   logic                   c1_req_data_valid;
   logic                   c1_req_data_ready;
   logic [DATA_BITS-1:0]   c1_req_data_bits;
   logic [DATA_BITS/8-1:0] c1_req_data_mask;
   logic                   c1_resp_valid;
   logic [DATA_BITS-1:0]   c1_resp_data;

   // Shared main-memory port
   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic [ADDR_BITS-1:0]   mem_req_addr;
   logic                   mem_req_rw;
   logic                   mem_req_data_valid;
   logic                   mem_req_data_ready;
   logic [DATA_BITS-1:0]   mem_req_data_bits;
   logic [DATA_BITS/8-1:0] mem_req_data_mask;
   logic                   mem_resp_valid;
   logic [DATA_BITS-1:0]   mem_resp_data;

   // Status
   logic                   busy;
   logic                   stray_resp;

   // Arbiter side
   modport slave (
      input  c0_req_valid, c0_req_addr, c0_req_rw,
             c0_req_data_valid, c0_req_data_bits, c0_req_data_mask,
      output c0_req_ready, c0_req_data_ready, c0_resp_valid, c0_resp_data,
      input  c1_req_valid, c1_req_addr, c1_req_rw,
             c1_req_data_valid, c1_req_data_bits, c1_req_data_mask,
      output c1_req_ready, c1_req_data_ready, c1_resp_valid, c1_resp_data,
      output mem_req_valid, mem_req_addr, mem_req_rw,
             mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
      input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
      output busy, stray_resp
   );

   // Cache / memory side
   modport master (
      output c0_req_valid, c0_req_addr, c0_req_rw,
             c0_req_data_valid, c0_req_data_bits, c0_req_data_mask,
      input  c0_req_ready, c0_req_data_ready, c0_resp_valid, c0_resp_data,
      output c1_req_valid, c1_req_addr, c1_req_rw,
             c1_req_data_valid, c1_req_data_bits, c1_req_data_mask,
      input  c1_req_ready, c1_req_data_ready, c1_resp_valid, c1_resp_data,
      input  mem_req_valid, mem_req_addr, mem_req_rw,
             mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
      output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
      input  busy, stray_resp
   );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the instruction
// cache (port 0) and the data cache (port 1). One transaction at a time,
// round-robin grant, zero-latency combinational request and response paths.
// A grant that has been presented to memory is held (locked) until it fires
// so that memory never sees a request withdrawn or swapped underneath it.
module mem_arbiter #(
   parameter int ADDR_BITS  = 28,
   parameter int DATA_BITS  = 128,
   parameter int READ_BEATS = 4
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam int MASK_BITS = DATA_BITS / 8;
   localparam int CNT_W     = $clog2(READ_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE_DATA,
      READ_RESP
   } state_t;

   state_t               r_state;
   logic                 r_owner;
   logic                 r_lastGrant;
   logic                 r_locked;
   logic                 r_lockedPort;
   logic [CNT_W-1:0]     r_beatCnt;
   logic                 r_strayResp;

   state_t               w_stateNext;
   logic                 w_ownerNext;
   logic                 w_lastGrantNext;
   logic                 w_lockedNext;
   logic                 w_lockedPortNext;
   logic [CNT_W-1:0]     w_beatCntNext;
   logic                 w_strayRespNext;

   logic                 w_grant;
   logic                 w_sel;
   logic                 w_selReqValid;
   logic [ADDR_BITS-1:0] w_selAddr;
   logic                 w_selRw;
   logic                 w_selDataValid;
   logic [DATA_BITS-1:0] w_selDataBits;
   logic [MASK_BITS-1:0] w_selDataMask;

   logic                 w_memReqValid;
   logic                 w_memDataValid;
   logic [1:0]           w_reqReady;
   logic [1:0]           w_dataReady;
   logic [1:0]           w_respValid;

   // Round-robin grant: a locked grant wins, a lone requester wins, and a
   // tie goes to whichever port was not granted last.
   always_comb begin
      w_grant = 1'b0;
      if (r_locked) begin
         w_grant = r_lockedPort;
      end else if (bus.c0_req_valid && bus.c1_req_valid) begin
         w_grant = ~r_lastGrant;
      end else if (bus.c1_req_valid) begin
         w_grant = 1'b1;
      end
   end

   // Payload mux: follow the grant while arbitrating, the owner afterwards.
   always_comb begin
      w_sel          = (r_state == IDLE) ? w_grant : r_owner;
      w_selReqValid  = w_sel ? bus.c1_req_valid      : bus.c0_req_valid;
      w_selAddr      = w_sel ? bus.c1_req_addr       : bus.c0_req_addr;
      w_selRw        = w_sel ? bus.c1_req_rw         : bus.c0_req_rw;
      w_selDataValid = w_sel ? bus.c1_req_data_valid : bus.c0_req_data_valid;
      w_selDataBits  = w_sel ? bus.c1_req_data_bits  : bus.c0_req_data_bits;
      w_selDataMask  = w_sel ? bus.c1_req_data_mask  : bus.c0_req_data_mask;
   end

   // Next-state and handshake logic; all ready/valid outputs are forced low
   // while reset is held so neither side sees a spurious handshake.
   always_comb begin
      w_stateNext      = r_state;
      w_ownerNext      = r_owner;
      w_lastGrantNext  = r_lastGrant;
      w_lockedNext     = r_locked;
      w_lockedPortNext = r_lockedPort;
      w_beatCntNext    = r_beatCnt;
      w_strayRespNext  = r_strayResp;
      w_memReqValid    = 1'b0;
      w_memDataValid   = 1'b0;
      w_reqReady       = 2'b00;
      w_dataReady      = 2'b00;
      w_respValid      = 2'b00;

      case (r_state)
         IDLE: begin
            w_memReqValid = w_selReqValid;
            if (w_grant) begin
               w_reqReady[1] = bus.mem_req_ready;
            end else begin
               w_reqReady[0] = bus.mem_req_ready;
            end
            if (w_memReqValid && bus.mem_req_ready) begin
               w_ownerNext     = w_grant;
               w_lastGrantNext = w_grant;
               w_lockedNext    = 1'b0;
               if (w_selRw) begin
                  w_stateNext = WRITE_DATA;
               end else begin
                  w_stateNext   = READ_RESP;
                  w_beatCntNext = '0;
               end
            end else if (w_memReqValid) begin
               w_lockedNext     = 1'b1;
               w_lockedPortNext = w_grant;
            end
            if (bus.mem_resp_valid) begin
               w_strayRespNext = 1'b1;
            end
         end

         WRITE_DATA: begin
            w_memDataValid = w_selDataValid;
            if (r_owner) begin
               w_dataReady[1] = bus.mem_req_data_ready;
            end else begin
               w_dataReady[0] = bus.mem_req_data_ready;
            end
            if (w_memDataValid && bus.mem_req_data_ready) begin
               w_stateNext = IDLE;
            end
            if (bus.mem_resp_valid) begin
               w_strayRespNext = 1'b1;
            end
         end

         READ_RESP: begin
            if (r_owner) begin
               w_respValid[1] = bus.mem_resp_valid;
            end else begin
               w_respValid[0] = bus.mem_resp_valid;
            end
            if (bus.mem_resp_valid) begin
               if (r_beatCnt == LAST_BEAT) begin
                  w_stateNext   = IDLE;
                  w_beatCntNext = '0;
               end else begin
                  w_beatCntNext = r_beatCnt + CNT_W'(1);
               end
            end
         end

         default: begin
            w_stateNext = IDLE;
         end
      endcase

      if (reset) begin
         w_memReqValid  = 1'b0;
         w_memDataValid = 1'b0;
         w_reqReady     = 2'b00;
         w_dataReady    = 2'b00;
         w_respValid    = 2'b00;
      end
   end

   // State register; last_grant resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_lastGrant  <= 1'b1;
         r_locked     <= 1'b0;
         r_lockedPort <= 1'b0;
         r_beatCnt    <= '0;
         r_strayResp  <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_owner      <= w_ownerNext;
         r_lastGrant  <= w_lastGrantNext;
         r_locked     <= w_lockedNext;
         r_lockedPort <= w_lockedPortNext;
         r_beatCnt    <= w_beatCntNext;
         r_strayResp  <= w_strayRespNext;
      end
   end

   assign bus.mem_req_valid      = w_memReqValid;
   assign bus.mem_req_addr       = w_selAddr;
   assign bus.mem_req_rw         = w_selRw;
   assign bus.mem_req_data_valid = w_memDataValid;
   assign bus.mem_req_data_bits  = w_selDataBits;
   assign bus.mem_req_data_mask  = w_selDataMask;

   assign bus.c0_req_ready       = w_reqReady[0];
   assign bus.c1_req_ready       = w_reqReady[1];
   assign bus.c0_req_data_ready  = w_dataReady[0];
   assign bus.c1_req_data_ready  = w_dataReady[1];
   assign bus.c0_resp_valid      = w_respValid[0];
   assign bus.c1_resp_valid      = w_respValid[1];
   assign bus.c0_resp_data       = bus.mem_resp_data;
   assign bus.c1_resp_data       = bus.mem_resp_data;

   assign bus.busy               = (r_state != IDLE);
   assign bus.stray_resp         = r_strayResp;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for the two-port memory arbiter.
// Inputs change just after the falling edge; outputs are sampled 1ns later,
// well away from the rising edge that advances the design.
module tb_mem_arbiter;

   localparam int ADDR_BITS  = 28;
   localparam int DATA_BITS  = 128;
   localparam int READ_BEATS = 4;

   logic clk;
   logic reset;
   int   nChecks;
   int   nFails;

   mem_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

   mem_arbiter #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .READ_BEATS(READ_BEATS)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running 10ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clearInputs();
      bus.c0_req_valid = 1'b0; bus.c0_req_addr = '0; bus.c0_req_rw = 1'b0;
      bus.c0_req_data_valid = 1'b0; bus.c0_req_data_bits = '0; bus.c0_req_data_mask = '0;
      bus.c1_req_valid = 1'b0; bus.c1_req_addr = '0; bus.c1_req_rw = 1'b0;
      bus.c1_req_data_valid = 1'b0; bus.c1_req_data_bits = '0; bus.c1_req_data_mask = '0;
      bus.mem_req_ready = 1'b0; bus.mem_req_data_ready = 1'b0;
      bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
   endtask

   task automatic resetPulse();
      reset = 1'b1;
      clearInputs();
      tick();
      reset = 1'b0;
   endtask

   // Reset holds every handshake output low even with all inputs active
   task automatic test_reset();
      bus.c0_req_valid = 1'b1; bus.c1_req_valid = 1'b1; bus.mem_req_ready = 1'b1;
      bus.mem_resp_valid = 1'b1; bus.c0_req_data_valid = 1'b1; bus.mem_req_data_ready = 1'b1;
      #1;
      nChecks++; if (bus.mem_req_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_req_valid got %0b want 0", bus.mem_req_valid); end
      nChecks++; if (bus.c0_req_ready !== 1'b0 || bus.c1_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req_ready got %0b%0b want 00", bus.c1_req_ready, bus.c0_req_ready); end
      nChecks++; if (bus.c0_resp_valid !== 1'b0 || bus.c1_resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_resp_valid got %0b%0b want 00", bus.c1_resp_valid, bus.c0_resp_valid); end
      nChecks++; if (bus.mem_req_data_valid !== 1'b0 || bus.c0_req_data_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_data_hs got %0b%0b want 00", bus.mem_req_data_valid, bus.c0_req_data_ready); end
      nChecks++; if (bus.busy !== 1'b0 || bus.stray_resp !== 1'b0) begin nFails++; $display("[TB] FAIL reset_status busy=%0b stray=%0b want 0 0", bus.busy, bus.stray_resp); end
      clearInputs();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // c0 line read with a one-cycle gap between beats 2 and 3
   task automatic test_single_read();
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 28'h0000123; bus.c0_req_rw = 1'b0;
      bus.mem_req_ready = 1'b1;
      #1;
      nChecks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 28'h0000123 || bus.mem_req_rw !== 1'b0) begin nFails++; $display("[TB] FAIL read_req got v=%0b a=%h rw=%0b want 1 0000123 0", bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_rw); end
      nChecks++; if (bus.c0_req_ready !== 1'b1 || bus.c1_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL read_ready got c0=%0b c1=%0b want 1 0", bus.c0_req_ready, bus.c1_req_ready); end
      tick();
      bus.c0_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
      for (int i = 0; i < READ_BEATS; i++) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data = 128'hA + 128'(i);
         #1;
         nChecks++; if (bus.c0_resp_valid !== 1'b1 || bus.c1_resp_valid !== 1'b0 || bus.c0_resp_data !== 128'hA + 128'(i)) begin nFails++; $display("[TB] FAIL read_beat%0d got c0=%0b c1=%0b d=%h want 1 0 %h", i, bus.c0_resp_valid, bus.c1_resp_valid, bus.c0_resp_data, 128'hA + 128'(i)); end
         nChecks++; if (bus.busy !== 1'b1) begin nFails++; $display("[TB] FAIL read_busy_beat%0d got %0b want 1", i, bus.busy); end
         tick();
         if (i == 1) begin
            bus.mem_resp_valid = 1'b0;
            #1;
            nChecks++; if (bus.c0_resp_valid !== 1'b0 || bus.busy !== 1'b1) begin nFails++; $display("[TB] FAIL read_gap got resp=%0b busy=%0b want 0 1", bus.c0_resp_valid, bus.busy); end
            tick();
         end
      end
      bus.mem_resp_valid = 1'b0;
      #1;
      nChecks++; if (bus.busy !== 1'b0 || bus.stray_resp !== 1'b0) begin nFails++; $display("[TB] FAIL read_done busy=%0b stray=%0b want 0 0", bus.busy, bus.stray_resp); end
      tick();
   endtask

   // Ties after reset: c0, then c1 (after turnaround), then c0 again
   task automatic test_simultaneous();
      resetPulse();
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 28'h10; bus.c0_req_rw = 1'b0;
      bus.c1_req_valid = 1'b1; bus.c1_req_addr = 28'h20; bus.c1_req_rw = 1'b1;
      bus.c1_req_data_bits = 128'h55; bus.c1_req_data_mask = 16'hFFFF;
      bus.mem_req_ready = 1'b1;
      #1;
      nChecks++; if (bus.mem_req_addr !== 28'h10 || bus.c0_req_ready !== 1'b1 || bus.c1_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL tie1 got a=%h c0=%0b c1=%0b want 10 1 0", bus.mem_req_addr, bus.c0_req_ready, bus.c1_req_ready); end
      tick();
      bus.c0_req_valid = 1'b0;
      for (int i = 0; i < READ_BEATS; i++) begin
         bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 128'(i);
         #1;
         nChecks++; if (bus.mem_req_valid !== 1'b0 || bus.c1_req_ready !== 1'b0 || bus.c1_resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL tie_hold_beat%0d got v=%0b c1rdy=%0b c1resp=%0b want 0 0 0", i, bus.mem_req_valid, bus.c1_req_ready, bus.c1_resp_valid); end
         tick();
      end
      bus.mem_resp_valid = 1'b0;
      #1;
      nChecks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 28'h20 || bus.mem_req_rw !== 1'b1 || bus.c1_req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL tie2 got v=%0b a=%h rw=%0b c1=%0b want 1 20 1 1", bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_rw, bus.c1_req_ready); end
      tick();
      bus.c1_req_valid = 1'b0; bus.c1_req_data_valid = 1'b1; bus.mem_req_data_ready = 1'b1;
      #1;
      nChecks++; if (bus.c1_req_data_ready !== 1'b1 || bus.mem_req_data_bits !== 128'h55) begin nFails++; $display("[TB] FAIL tie2_data got rdy=%0b d=%h want 1 55", bus.c1_req_data_ready, bus.mem_req_data_bits); end
      tick();
      bus.c1_req_data_valid = 1'b0; bus.mem_req_data_ready = 1'b0;
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 28'h30;
      bus.c1_req_valid = 1'b1; bus.c1_req_addr = 28'h40; bus.c1_req_rw = 1'b0;
      #1;
      nChecks++; if (bus.mem_req_addr !== 28'h30 || bus.c0_req_ready !== 1'b1 || bus.c1_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL tie3 got a=%h c0=%0b c1=%0b want 30 1 0", bus.mem_req_addr, bus.c0_req_ready, bus.c1_req_ready); end
      resetPulse();
   endtask

   // c1 stalled by memory for 3 cycles keeps the grant after c0 arrives
   task automatic test_grant_lock();
      int pulses;
      pulses = 0;
      bus.c1_req_valid = 1'b1; bus.c1_req_addr = 28'h0ABCDEF; bus.c1_req_rw = 1'b0;
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus.c1_req_ready === 1'b1) pulses++;
         nChecks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 28'h0ABCDEF) begin nFails++; $display("[TB] FAIL lock_stall%0d got v=%0b a=%h want 1 0abcdef", i, bus.mem_req_valid, bus.mem_req_addr); end
         tick();
      end
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 28'h0000111;
      #1;
      if (bus.c1_req_ready === 1'b1) pulses++;
      nChecks++; if (bus.mem_req_addr !== 28'h0ABCDEF || bus.c0_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL lock_hold got a=%h c0rdy=%0b want 0abcdef 0", bus.mem_req_addr, bus.c0_req_ready); end
      tick();
      bus.mem_req_ready = 1'b1;
      #1;
      if (bus.c1_req_ready === 1'b1) pulses++;
      nChecks++; if (bus.mem_req_addr !== 28'h0ABCDEF || bus.c0_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL lock_fire got a=%h c0rdy=%0b want 0abcdef 0", bus.mem_req_addr, bus.c0_req_ready); end
      tick();
      bus.c1_req_valid = 1'b0;
      #1;
      if (bus.c1_req_ready === 1'b1) pulses++;
      nChecks++; if (pulses != 1) begin nFails++; $display("[TB] FAIL lock_ready_pulses got %0d want 1", pulses); end
      resetPulse();
   endtask

   // c1 write-through with memory data-ready delayed two cycles
   task automatic test_write_through();
      int fires;
      logic [DATA_BITS-1:0] wd;
      fires = 0;
      wd = 128'h0000_0000_DEAD_BEEF_0000_0000_0000_0000;
      bus.c1_req_valid = 1'b1; bus.c1_req_addr = 28'h40; bus.c1_req_rw = 1'b1;
      bus.c1_req_data_valid = 1'b1; bus.c1_req_data_bits = wd; bus.c1_req_data_mask = 16'h0F00;
      bus.c0_req_data_valid = 1'b1; bus.c0_req_data_bits = 128'h1234; bus.c0_req_data_mask = 16'hFFFF;
      bus.mem_req_ready = 1'b1; bus.mem_req_data_ready = 1'b1;
      #1;
      nChecks++; if (bus.mem_req_rw !== 1'b1 || bus.mem_req_addr !== 28'h40 || bus.c1_req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL wr_req got rw=%0b a=%h rdy=%0b want 1 40 1", bus.mem_req_rw, bus.mem_req_addr, bus.c1_req_ready); end
      nChecks++; if (bus.mem_req_data_valid !== 1'b0 || bus.c1_req_data_ready !== 1'b0 || bus.c0_req_data_ready !== 1'b0) begin nFails++; $display("[TB] FAIL wr_early_data got v=%0b c1=%0b c0=%0b want 0 0 0", bus.mem_req_data_valid, bus.c1_req_data_ready, bus.c0_req_data_ready); end
      tick();
      bus.c1_req_valid = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_req_data_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) bus.mem_req_data_ready = 1'b1;
         #1;
         if (bus.mem_req_data_valid === 1'b1 && bus.mem_req_data_ready === 1'b1) fires++;
         nChecks++; if (bus.mem_req_data_valid !== 1'b1 || bus.mem_req_data_bits !== wd || bus.mem_req_data_mask !== 16'h0F00) begin nFails++; $display("[TB] FAIL wr_data%0d got v=%0b d=%h m=%h want 1 %h 0f00", i, bus.mem_req_data_valid, bus.mem_req_data_bits, bus.mem_req_data_mask, wd); end
         nChecks++; if (bus.c1_req_data_ready !== (i == 2) || bus.c0_req_data_ready !== 1'b0 || bus.busy !== 1'b1) begin nFails++; $display("[TB] FAIL wr_ready%0d got c1=%0b c0=%0b busy=%0b want %0b 0 1", i, bus.c1_req_data_ready, bus.c0_req_data_ready, bus.busy, i == 2); end
         tick();
      end
      #1;
      if (bus.mem_req_data_valid === 1'b1 && bus.mem_req_data_ready === 1'b1) fires++;
      nChecks++; if (bus.c1_req_data_ready !== 1'b0 || bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL wr_after got rdy=%0b busy=%0b want 0 0", bus.c1_req_data_ready, bus.busy); end
      nChecks++; if (fires != 1) begin nFails++; $display("[TB] FAIL wr_fire_count got %0d want 1", fires); end
      clearInputs();
      tick();
   endtask

   // Stray beat in IDLE, then reset in the middle of a read
   task automatic test_stray_and_reset();
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 128'h77;
      #1;
      nChecks++; if (bus.c0_resp_valid !== 1'b0 || bus.c1_resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL stray_leak got c0=%0b c1=%0b want 0 0", bus.c0_resp_valid, bus.c1_resp_valid); end
      tick();
      bus.mem_resp_valid = 1'b0;
      #1;
      nChecks++; if (bus.stray_resp !== 1'b1) begin nFails++; $display("[TB] FAIL stray_set got %0b want 1", bus.stray_resp); end
      tick();
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 28'h200; bus.c0_req_rw = 1'b0; bus.mem_req_ready = 1'b1;
      #1;
      nChecks++; if (bus.stray_resp !== 1'b1 || bus.c0_req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL stray_sticky got stray=%0b rdy=%0b want 1 1", bus.stray_resp, bus.c0_req_ready); end
      tick();
      bus.c0_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.mem_resp_valid = 1'b1;
         tick();
      end
      reset = 1'b1;
      bus.mem_resp_valid = 1'b0;
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 28'h300; bus.mem_req_ready = 1'b1;
      #1;
      nChecks++; if (bus.busy !== 1'b0 || bus.stray_resp !== 1'b0 || bus.mem_req_valid !== 1'b0) begin nFails++; $display("[TB] FAIL midreset got busy=%0b stray=%0b v=%0b want 0 0 0", bus.busy, bus.stray_resp, bus.mem_req_valid); end
      tick();
      reset = 1'b0;
      #1;
      nChecks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 28'h300 || bus.c0_req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_req got v=%0b a=%h rdy=%0b want 1 300 1", bus.mem_req_valid, bus.mem_req_addr, bus.c0_req_ready); end
      tick();
      bus.c0_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
      for (int i = 0; i < READ_BEATS; i++) begin
         bus.mem_resp_valid = 1'b1;
         #1;
         nChecks++; if (bus.busy !== 1'b1 || bus.c0_resp_valid !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_beat%0d got busy=%0b resp=%0b want 1 1", i, bus.busy, bus.c0_resp_valid); end
         tick();
      end
      bus.mem_resp_valid = 1'b0;
      #1;
      nChecks++; if (bus.busy !== 1'b0 || bus.stray_resp !== 1'b0) begin nFails++; $display("[TB] FAIL post_reset_done got busy=%0b stray=%0b want 0 0", bus.busy, bus.stray_resp); end
      tick();
   endtask

   // Scenario sequence
   initial begin
      nChecks = 0;
      nFails  = 0;
      reset   = 1'b1;
      clearInputs();
      tick();
      test_reset();
      test_single_read();
      test_simultaneous();
      test_grant_lock();
      test_write_through();
      test_stray_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
